// File: rtl/khu_uart_pkg.sv
// ---------------------------------------------------------------------------
// khu_uart_pkg
// Shared UART definitions for the KHU serial blocks (RX today, TX reuses them).
//   uart_state_t       - frame FSM states: idle, start bit, data bits, stop bit
//   UART_CLKS_PER_BIT  - default system clocks per bit (50 MHz / 115200)
//   uart_half_bit()    - counter value at which the start bit is re-checked
// ---------------------------------------------------------------------------
package khu_uart_pkg;

   localparam int unsigned UART_CLKS_PER_BIT = 434;

   typedef enum logic [1:0] {
      UART_IDLE  = 2'd0,
      UART_START = 2'd1,
      UART_DATA  = 2'd2,
      UART_STOP  = 2'd3
   } uart_state_t;

   // The start bit is re-sampled half a bit after the falling edge; every
   // later sample is a whole bit after that, landing in the middle of each bit.
   function automatic int unsigned uart_half_bit(input int unsigned clks_per_bit);
      return (clks_per_bit / 2) - 1;
   endfunction

endpackage

// File: rtl/khu_sync.sv
// ---------------------------------------------------------------------------
// khu_sync
// Multi-flop synchronizer for a single asynchronous input bit.
// Used for UART_RXD and for the ADS1292 DRDY / MISO pad inputs.
// Parameters:
//   DEPTH   - number of flip-flops in the chain (2 or 3)
//   RST_VAL - value every stage takes during reset (idle level of the line)
// Ports:
//   clk   - destination clock
//   rst_n - asynchronous active-low reset
//   d     - asynchronous input
//   q     - synchronized output, DEPTH clocks behind d
// ---------------------------------------------------------------------------
module khu_sync #(
   parameter int unsigned DEPTH   = 2,
   parameter logic        RST_VAL = 1'b1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic [DEPTH-1:0] stages;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stages <= {DEPTH{RST_VAL}};
      end else begin
         stages <= {stages[DEPTH-2:0], d};
      end
   end

   assign q = stages[DEPTH-1];

endmodule

// File: rtl/khu_uart_rx.sv
// ---------------------------------------------------------------------------
// khu_uart_rx
// 8N1 UART receiver with a one-byte holding register and valid/ready output.
// Parameters:
//   CLKS_PER_BIT - system clocks per UART bit (8..65535)
//   SYNC_STAGES  - depth of the RXD synchronizer (2..3)
// Ports:
//   CLK          - system clock
//   RSTN         - asynchronous active-low reset
//   UART_RXD     - serial input, asynchronous, idle high
//   RX_DATA      - received byte, valid while RX_VALID is high
//   RX_VALID     - holding register contains a byte for the consumer
//   RX_READY     - consumer takes the byte when RX_VALID && RX_READY
//   RX_FRAME_ERR - one-cycle pulse when a stop bit is sampled low
//   RX_OVERRUN   - sticky: a byte was dropped because the holding reg was full
//   RX_BUSY      - receiver FSM is not idle
// ---------------------------------------------------------------------------
module khu_uart_rx
   import khu_uart_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = UART_CLKS_PER_BIT,
   parameter int unsigned SYNC_STAGES  = 2
) (
   input  logic       CLK,
   input  logic       RSTN,
   input  logic       UART_RXD,
   output logic [7:0] RX_DATA,
   output logic       RX_VALID,
   input  logic       RX_READY,
   output logic       RX_FRAME_ERR,
   output logic       RX_OVERRUN,
   output logic       RX_BUSY
);

   localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(uart_half_bit(CLKS_PER_BIT));
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

   logic             rxd_s;      // synchronized line
   logic             rxd_prev;   // previous synchronized value, for edge detect
   uart_state_t      state;
   logic [CNT_W-1:0] cnt;
   logic [2:0]       bit_idx;
   logic [7:0]       shift_reg;

   khu_sync #(
      .DEPTH   (SYNC_STAGES),
      .RST_VAL (1'b1)
   ) u_rxd_sync (
      .clk   (CLK),
      .rst_n (RSTN),
      .d     (UART_RXD),
      .q     (rxd_s)
   );

   // Frame FSM and holding register share one block so that a byte landing
   // on the same cycle the consumer takes the previous one is resolved in a
   // single place: the load below overrides the release done at the top.
   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         state        <= UART_IDLE;
         cnt          <= '0;
         bit_idx      <= '0;
         shift_reg    <= '0;
         rxd_prev     <= 1'b1;
         RX_DATA      <= '0;
         RX_VALID     <= 1'b0;
         RX_FRAME_ERR <= 1'b0;
         RX_OVERRUN   <= 1'b0;
         RX_BUSY      <= 1'b0;
      end else begin
         rxd_prev     <= rxd_s;
         RX_FRAME_ERR <= 1'b0;

         if (RX_VALID && RX_READY) begin
            RX_VALID <= 1'b0;
         end

         case (state)
            UART_IDLE: begin
               // Only a true 1->0 transition starts a frame; a line held low
               // after a framing error (break) never retriggers.
               if (rxd_prev && !rxd_s) begin
                  state   <= UART_START;
                  cnt     <= '0;
                  RX_BUSY <= 1'b1;
               end
            end

            UART_START: begin
               if (cnt == CNT_HALF) begin
                  cnt <= '0;
                  if (!rxd_s) begin
                     state   <= UART_DATA;
                     bit_idx <= '0;
                  end else begin
                     // Glitch shorter than half a bit: drop silently.
                     state   <= UART_IDLE;
                     RX_BUSY <= 1'b0;
                  end
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end

            UART_DATA: begin
               if (cnt == CNT_LAST) begin
                  cnt       <= '0;
                  shift_reg <= {rxd_s, shift_reg[7:1]};
                  if (bit_idx == 3'd7) begin
                     state <= UART_STOP;
                  end else begin
                     bit_idx <= bit_idx + 3'd1;
                  end
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end

            UART_STOP: begin
               if (cnt == CNT_LAST) begin
                  cnt     <= '0;
                  state   <= UART_IDLE;
                  RX_BUSY <= 1'b0;
                  if (rxd_s) begin
                     if (!RX_VALID || RX_READY) begin
                        RX_DATA  <= shift_reg;
                        RX_VALID <= 1'b1;
                     end else begin
                        RX_OVERRUN <= 1'b1;
                     end
                  end else begin
                     RX_FRAME_ERR <= 1'b1;
                  end
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end

            default: begin
               state   <= UART_IDLE;
               cnt     <= '0;
               RX_BUSY <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_khu_uart_rx.sv
// ---------------------------------------------------------------------------
// tb_khu_uart_rx
// Self-checking bench for khu_uart_rx at CLKS_PER_BIT=16. Expected bytes are
// queued when a frame is sent and compared when the consumer accepts them.
// ---------------------------------------------------------------------------
module tb_khu_uart_rx;

   localparam int unsigned CPB = 16;

   logic       clk;
   logic       rst_n;
   logic       rxd;
   logic       rx_ready;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_frame_err;
   logic       rx_overrun;
   logic       rx_busy;

   int tests;
   int fails;
   int valid_cycles;
   int valid_low_cycles;
   int ferr_cycles;
   int busy_cycles;
   int accept_cnt;
   logic [7:0] exp_q[$];
   logic [7:0] exp_b;
   bit rand_on;

   khu_uart_rx #(
      .CLKS_PER_BIT (CPB),
      .SYNC_STAGES  (2)
   ) dut (
      .CLK          (clk),
      .RSTN         (rst_n),
      .UART_RXD     (rxd),
      .RX_DATA      (rx_data),
      .RX_VALID     (rx_valid),
      .RX_READY     (rx_ready),
      .RX_FRAME_ERR (rx_frame_err),
      .RX_OVERRUN   (rx_overrun),
      .RX_BUSY      (rx_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Scoreboard monitor: samples 1 time unit after the falling edge, i.e. the
   // values that the next rising edge will act on.
   always @(negedge clk) begin
      #1;
      if (rst_n) begin
         if (rx_valid) valid_cycles++;
         else          valid_low_cycles++;
         if (rx_frame_err) ferr_cycles++;
         if (rx_busy)      busy_cycles++;
         if (rx_valid && rx_ready) begin
            accept_cnt++;
            tests++;
            if (exp_q.size() == 0) begin
               fails++;
               $display("FAIL sb_unexpected: got %h, expected no byte", rx_data);
            end else begin
               exp_b = exp_q.pop_front();
               if (rx_data !== exp_b) begin
                  fails++;
                  $display("FAIL sb_data: got %h, expected %h", rx_data, exp_b);
               end
            end
         end
      end
   end

   // Drives one 8N1 frame starting at the current falling edge. With jitter,
   // each bit lasts 15..17 clocks but the accumulated drift stays within +-1.
   task automatic send_byte(input logic [7:0] b, input logic stop_val, input bit jitter);
      logic [9:0] frame;
      int off;
      int p;
      frame = {stop_val, b, 1'b0};
      off = 0;
      for (int i = 0; i < 10; i++) begin
         rxd = frame[i];
         p = CPB;
         if (jitter) begin
            p = 15 + int'($urandom_range(0, 2));
            if ((off + p - 16) > 1 || (off + p - 16) < -1) p = 16;
            off = off + p - 16;
         end
         repeat (p) @(negedge clk);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      rxd = 1'b1;
      rx_ready = 1'b0;
      repeat (3) @(negedge clk);
      tests += 5;
      if (rx_valid !== 1'b0)     begin fails++; $display("FAIL reset_valid: got %b, expected 0", rx_valid); end
      if (rx_data !== 8'h00)     begin fails++; $display("FAIL reset_data: got %h, expected 00", rx_data); end
      if (rx_frame_err !== 1'b0) begin fails++; $display("FAIL reset_ferr: got %b, expected 0", rx_frame_err); end
      if (rx_overrun !== 1'b0)   begin fails++; $display("FAIL reset_overrun: got %b, expected 0", rx_overrun); end
      if (rx_busy !== 1'b0)      begin fails++; $display("FAIL reset_busy: got %b, expected 0", rx_busy); end
      rst_n = 1'b1;
      repeat (5) @(negedge clk);
   endtask

   task automatic test_single();
      rx_ready = 1'b1;
      valid_cycles = 0;
      ferr_cycles = 0;
      exp_q.push_back(8'hA5);
      send_byte(8'hA5, 1'b1, 1'b0);
      repeat (20) @(negedge clk);
      tests += 3;
      if (valid_cycles != 1) begin fails++; $display("FAIL single_valid_cycles: got %0d, expected 1", valid_cycles); end
      if (ferr_cycles != 0)  begin fails++; $display("FAIL single_ferr: got %0d, expected 0", ferr_cycles); end
      if (exp_q.size() != 0) begin fails++; $display("FAIL single_pending: got %0d, expected 0", exp_q.size()); end
   endtask

   task automatic test_glitch();
      valid_cycles = 0;
      busy_cycles = 0;
      rxd = 1'b0;
      repeat (CPB / 4) @(negedge clk);
      rxd = 1'b1;
      repeat (30) @(negedge clk);
      tests += 4;
      if (busy_cycles < 1 || busy_cycles > 8) begin fails++; $display("FAIL glitch_busy_cycles: got %0d, expected 1..8", busy_cycles); end
      if (rx_busy !== 1'b0)  begin fails++; $display("FAIL glitch_busy_end: got %b, expected 0", rx_busy); end
      if (valid_cycles != 0) begin fails++; $display("FAIL glitch_valid: got %0d, expected 0", valid_cycles); end
      if (rx_data !== 8'hA5) begin fails++; $display("FAIL glitch_data: got %h, expected a5", rx_data); end
   endtask

   task automatic test_frame_err();
      valid_cycles = 0;
      ferr_cycles = 0;
      send_byte(8'h3C, 1'b0, 1'b0);
      busy_cycles = 0;
      repeat (3 * CPB) @(negedge clk);
      tests += 4;
      if (ferr_cycles != 1)  begin fails++; $display("FAIL ferr_pulse: got %0d, expected 1", ferr_cycles); end
      if (valid_cycles != 0) begin fails++; $display("FAIL ferr_valid: got %0d, expected 0", valid_cycles); end
      if (busy_cycles != 0)  begin fails++; $display("FAIL ferr_break_retrigger: got %0d, expected 0", busy_cycles); end
      if (rx_data !== 8'hA5) begin fails++; $display("FAIL ferr_data: got %h, expected a5", rx_data); end
      rxd = 1'b1;
      repeat (20) @(negedge clk);
      valid_cycles = 0;
      exp_q.push_back(8'h5A);
      send_byte(8'h5A, 1'b1, 1'b0);
      repeat (20) @(negedge clk);
      tests += 2;
      if (valid_cycles != 1) begin fails++; $display("FAIL ferr_recover_valid: got %0d, expected 1", valid_cycles); end
      if (exp_q.size() != 0) begin fails++; $display("FAIL ferr_recover_pending: got %0d, expected 0", exp_q.size()); end
   endtask

   task automatic test_back_to_back();
      rx_ready = 1'b0;
      exp_q.push_back(8'h11);
      send_byte(8'h11, 1'b1, 1'b0);
      send_byte(8'h22, 1'b1, 1'b0);
      repeat (20) @(negedge clk);
      tests += 3;
      if (rx_data !== 8'h11)   begin fails++; $display("FAIL b2b_data: got %h, expected 11", rx_data); end
      if (rx_valid !== 1'b1)   begin fails++; $display("FAIL b2b_valid: got %b, expected 1", rx_valid); end
      if (rx_overrun !== 1'b1) begin fails++; $display("FAIL b2b_overrun: got %b, expected 1", rx_overrun); end

      // Stop bit is sampled on the rising edge 154.5 clocks after the start
      // bit is driven (2 sync flops + edge detect + 8 + 9*16), so READY is
      // raised only over that edge.
      valid_low_cycles = 0;
      exp_q.push_back(8'h22);
      fork
         send_byte(8'h22, 1'b1, 1'b0);
         begin
            repeat (154) @(negedge clk);
            rx_ready = 1'b1;
            @(negedge clk);
            rx_ready = 1'b0;
         end
      join
      repeat (2) @(negedge clk);
      tests += 5;
      if (rx_data !== 8'h22)     begin fails++; $display("FAIL accept_load_data: got %h, expected 22", rx_data); end
      if (rx_valid !== 1'b1)     begin fails++; $display("FAIL accept_load_valid: got %b, expected 1", rx_valid); end
      if (valid_low_cycles != 0) begin fails++; $display("FAIL accept_load_gap: got %0d, expected 0", valid_low_cycles); end
      if (exp_q.size() != 1)     begin fails++; $display("FAIL accept_load_pending: got %0d, expected 1", exp_q.size()); end
      if (rx_overrun !== 1'b1)   begin fails++; $display("FAIL overrun_sticky: got %b, expected 1", rx_overrun); end
      rx_ready = 1'b1;
      repeat (5) @(negedge clk);
      tests += 2;
      if (rx_valid !== 1'b0) begin fails++; $display("FAIL drain_valid: got %b, expected 0", rx_valid); end
      if (exp_q.size() != 0) begin fails++; $display("FAIL drain_pending: got %0d, expected 0", exp_q.size()); end
   endtask

   task automatic test_reset_midframe();
      rx_ready = 1'b1;
      valid_cycles = 0;
      rxd = 1'b0;
      repeat (CPB) @(negedge clk);
      rxd = 1'b1;
      repeat (4 * CPB + CPB / 2) @(negedge clk);
      rst_n = 1'b0;
      #1;
      tests += 5;
      if (rx_busy !== 1'b0)      begin fails++; $display("FAIL midrst_busy: got %b, expected 0", rx_busy); end
      if (rx_valid !== 1'b0)     begin fails++; $display("FAIL midrst_valid: got %b, expected 0", rx_valid); end
      if (rx_data !== 8'h00)     begin fails++; $display("FAIL midrst_data: got %h, expected 00", rx_data); end
      if (rx_frame_err !== 1'b0) begin fails++; $display("FAIL midrst_ferr: got %b, expected 0", rx_frame_err); end
      if (rx_overrun !== 1'b0)   begin fails++; $display("FAIL midrst_overrun: got %b, expected 0", rx_overrun); end
      repeat (4) @(negedge clk);
      rst_n = 1'b1;
      repeat (10 * CPB) @(negedge clk);
      tests += 1;
      if (valid_cycles != 0) begin fails++; $display("FAIL midrst_no_valid: got %0d, expected 0", valid_cycles); end
      exp_q.push_back(8'h0F);
      send_byte(8'h0F, 1'b1, 1'b0);
      repeat (20) @(negedge clk);
      tests += 2;
      if (valid_cycles != 1) begin fails++; $display("FAIL midrst_next_valid: got %0d, expected 1", valid_cycles); end
      if (exp_q.size() != 0) begin fails++; $display("FAIL midrst_next_pending: got %0d, expected 0", exp_q.size()); end
   endtask

   task automatic test_random();
      int waited;
      logic [7:0] b;
      accept_cnt = 0;
      rand_on = 1'b1;
      fork
         begin
            for (int n = 0; n < 256; n++) begin
               b = 8'($urandom_range(0, 255));
               exp_q.push_back(b);
               send_byte(b, 1'b1, 1'b1);
               repeat ($urandom_range(0, 3)) @(negedge clk);
            end
            rand_on = 1'b0;
         end
         begin
            while (rand_on) begin
               @(negedge clk);
               rx_ready = 1'($urandom_range(0, 1));
            end
         end
      join
      rx_ready = 1'b1;
      waited = 0;
      while (exp_q.size() != 0 && waited < 500) begin
         @(negedge clk);
         waited++;
      end
      repeat (2) @(negedge clk);
      tests += 3;
      if (exp_q.size() != 0)   begin fails++; $display("FAIL rand_pending: got %0d, expected 0", exp_q.size()); end
      if (accept_cnt != 256)   begin fails++; $display("FAIL rand_count: got %0d, expected 256", accept_cnt); end
      if (rx_overrun !== 1'b0) begin fails++; $display("FAIL rand_overrun: got %b, expected 0", rx_overrun); end
   endtask

   initial begin
      tests = 0;
      fails = 0;
      valid_cycles = 0;
      valid_low_cycles = 0;
      ferr_cycles = 0;
      busy_cycles = 0;
      accept_cnt = 0;
      rand_on = 1'b0;
      rst_n = 1'b0;
      rxd = 1'b1;
      rx_ready = 1'b0;
      @(negedge clk);
      test_reset();
      test_single();
      test_glitch();
      test_frame_err();
      test_back_to_back();
      test_reset_midframe();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/khu_uart_rx.md
KHU_UART_RX -- requirements
Module: khu_uart_rx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 434, meaning system clocks per UART bit (50 MHz / 115200); legal range 8..65535.
REQ-002 SHALL have parameter SYNC_STAGES, default 2, meaning the depth of the RXD metastability synchronizer; legal range 2..3.
REQ-003 SHALL have port CLK  input  1  system clock; the block uses this one clock only.
REQ-004 SHALL have port RSTN  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port UART_RXD  input  1  serial line from the input pad buffer, asynchronous to CLK, idle high.
REQ-006 SHALL have port RX_DATA  output  8  received byte, valid while RX_VALID=1.
REQ-007 SHALL have port RX_VALID  output  1  a byte is held for the consumer.
REQ-008 SHALL have port RX_READY  input  1  consumer accepts the byte.
REQ-009 SHALL have port RX_FRAME_ERR  output  1  one-cycle pulse when the stop bit is sampled low.
REQ-010 SHALL have port RX_OVERRUN  output  1  sticky flag: a byte was dropped because the holding register was full.
REQ-011 SHALL have port RX_BUSY  output  1  high while the FSM is not in IDLE.

Function
REQ-012 SHALL pass UART_RXD through SYNC_STAGES flip-flops, each reset to 1; all logic uses only the synchronized bit.
REQ-013 SHALL implement FSM states IDLE, START, DATA, STOP.
REQ-014 SHALL go IDLE->START on a synchronized 1->0 edge and load bit counter cnt=0.
REQ-015 In START, at cnt=CLKS_PER_BIT/2-1 (integer division), SHALL go to DATA if the line is still 0; if the line is 1 (glitch), SHALL return to IDLE with no outputs changed.
REQ-016 SHALL sample each data bit at the mid-bit point, every CLKS_PER_BIT cycles after the START sample, LSB first, into an 8-bit shift register; a 3-bit index counts 0..7.
REQ-017 After bit 7, SHALL go to STOP and sample the stop bit CLKS_PER_BIT cycles later.
REQ-018 On a stop bit of 1, SHALL try to write the byte to the holding register; on a stop bit of 0, SHALL pulse RX_FRAME_ERR for 1 cycle and discard the byte.
REQ-019 After the stop sample, SHALL return to IDLE on the same cycle; if the line is low, SHALL wait for a high before accepting a new falling edge (a break does not retrigger).
REQ-020 SHALL assert RX_VALID on the cycle after the stop sample, with RX_DATA stable until the cycle where RX_VALID&&RX_READY, and deassert it on the next cycle.
REQ-021 If a byte completes while RX_VALID=1 and RX_READY=0 on that cycle, SHALL keep the old byte, drop the new one, and set RX_OVERRUN.
REQ-022 If a byte completes on the same cycle that the old byte is accepted (RX_VALID&&RX_READY), SHALL load the new byte, keep RX_VALID high, and not set RX_OVERRUN.
REQ-023 RX_OVERRUN SHALL clear only on reset.
REQ-024 The counter SHALL be $clog2(CLKS_PER_BIT) bits wide, SHALL reset to 0 on every state change, and SHALL never wrap within a state.

Reset
REQ-025 On RSTN=0, SHALL asynchronously set: FSM=IDLE, counters=0, shift register=0, RX_DATA=8'h00, RX_VALID=0, RX_FRAME_ERR=0, RX_OVERRUN=0, RX_BUSY=0, synchronizer flops=1.
REQ-026 Reset asserted mid-frame SHALL abort the frame with no RX_VALID pulse; after deassertion, the first falling edge starts a new frame.

Structure
REQ-027 The FSM state enum and the default CLKS_PER_BIT constant SHALL live in shared package khu_uart_pkg, for reuse by the UART TX.
REQ-028 The synchronizer SHALL be sub-module khu_sync (parameterized depth and reset value); it is also reused for the ADS1292_DRDY and ADS1292_MISO inputs.

Verification (CLKS_PER_BIT=16)
REQ-029 Send 8'hA5 with a valid stop bit, RX_READY=1 -> one RX_VALID cycle with RX_DATA=8'hA5; RX_FRAME_ERR=0.
REQ-030 Send a 0.25-bit low glitch on an idle line -> no RX_VALID, RX_BUSY returns to 0 within 8 clocks.
REQ-031 Send 8'h3C with the stop bit driven 0 -> RX_FRAME_ERR pulses for 1 cycle, no RX_VALID, and no new frame until the line goes high.
REQ-032 Send 8'h11 then 8'h22 back-to-back with RX_READY=0 -> RX_DATA stays 8'h11, RX_OVERRUN=1; send 8'h22 again with RX_READY raised on its completion cycle -> RX_DATA=8'h22, no additional drop.
REQ-033 Assert RSTN low during data bit 4 of 8'hFF -> all outputs return to their reset values; the next frame 8'h0F is received correctly.
REQ-034 Run 256 random bytes with line bit periods of 15 to 17 clocks and random RX_READY -> all bytes match in order, with no overrun while the consumer keeps up.
